// File: rtl/alu_req_master.sv
// alu_req_master: packs client requests into ALU commands and tracks them in order.
// Returning results are paired with their operands; div-by-zero completes locally.
module alu_req_master #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic [9:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic       rsp_valid,
  input  logic [8:0] rsp_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [1:0] out_op,
  output logic [8:0] out_result,
  output logic       out_dz,
  output logic       err_unexp
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_next;

  logic [3:0]    r_ta  [MAX_OUTSTANDING];
  logic [3:0]    r_tb  [MAX_OUTSTANDING];
  logic [1:0]    r_top [MAX_OUTSTANDING];
  logic          r_tloc[MAX_OUTSTANDING];
  logic [8:0]    r_rb  [MAX_OUTSTANDING];
  logic [PW-1:0] r_twp, r_trp, r_rwp, r_rrp;
  logic [CW-1:0] r_tcnt, r_rcnt, r_rem;
  logic [9:0]    r_cmd;
  logic          r_live;

  logic w_acc, w_dz, w_issue, w_rpush;
  logic w_hloc, w_hrdy, w_load, w_rpop;

  assign w_acc   = req_valid && req_ready;
  assign w_dz    = (req_op == 2'd3) && (req_b == 4'd0);
  assign w_issue = cmd_valid && cmd_ready;
  assign w_rpush = rsp_valid && (r_rem != '0);
  assign w_hloc  = r_tloc[r_trp];
  assign w_hrdy  = (r_tcnt != '0) && (w_hloc || (r_rcnt != '0));
  assign w_load  = w_hrdy && (!out_valid || out_ready);
  assign w_rpop  = w_load && !w_hloc;
  assign cmd_data = r_cmd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_acc && !w_dz) w_next = SEND;
      SEND: if (cmd_ready) w_next = IDLE;
    endcase
  end

  // r_live holds req_ready low until the first edge after reset release
  always_comb begin
    req_ready = r_live && (r_state == IDLE) && (r_tcnt != FULL);
    cmd_valid = (r_state == SEND);
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_ta[r_twp]   <= req_a;
      r_tb[r_twp]   <= req_b;
      r_top[r_twp]  <= req_op;
      r_tloc[r_twp] <= w_dz;
    end
    if (w_rpush) r_rb[r_rwp] <= rsp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_twp  <= '0;
      r_trp  <= '0;
      r_tcnt <= '0;
      r_rwp  <= '0;
      r_rrp  <= '0;
      r_rcnt <= '0;
      r_rem  <= '0;
      r_cmd  <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (w_acc) r_twp <= r_twp + 1'b1;
      if (w_load) r_trp <= r_trp + 1'b1;
      r_tcnt <= r_tcnt + CW'(w_acc) - CW'(w_load);
      if (w_rpush) r_rwp <= r_rwp + 1'b1;
      if (w_rpop) r_rrp <= r_rrp + 1'b1;
      r_rcnt <= r_rcnt + CW'(w_rpush) - CW'(w_rpop);
      r_rem  <= r_rem + CW'(w_issue) - CW'(w_rpush);
      if (w_acc && !w_dz) r_cmd <= {req_op, req_b, req_a};
      if (rsp_valid && (r_rem == '0)) err_unexp <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_op     <= '0;
      out_result <= '0;
      out_dz     <= 1'b0;
    end else if (w_load) begin
      out_valid  <= 1'b1;
      out_a      <= r_ta[r_trp];
      out_b      <= r_tb[r_trp];
      out_op     <= r_top[r_trp];
      out_result <= w_hloc ? 9'd0 : r_rb[r_rrp];
      out_dz     <= w_hloc;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_master.sv
// tb_alu_req_master: bench acts as client and ALU, checking completions
// against an in-order queue model of the request stream.
module tb_alu_req_master;
  logic       clk = 0;
  logic       reset;
  logic       req_valid = 0;
  logic [3:0] req_a = 0, req_b = 0;
  logic [1:0] req_op = 0;
  logic       req_ready;
  logic [9:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1;
  logic       rsp_valid = 0;
  logic [8:0] rsp_data = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [3:0] out_a, out_b;
  logic [1:0] out_op;
  logic [8:0] out_result;
  logic       out_dz;
  logic       err_unexp;

  alu_req_master #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_result(out_result), .out_dz(out_dz),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [8:0] res;
    logic       dz;
  } exp_t;

  exp_t       m_exp[$];
  logic [9:0] m_cmd[$];
  logic [8:0] pend_v[$];
  int         pend_t[$];
  int  m_rem = 0;
  bit  m_err = 0;
  bit  m_acc, m_rsp;
  bit  hold_rsp = 0;
  int  rsp_dly = 1;
  int  ncyc = 0;
  int  nvec = 0, nerr = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] op);
    case (op)
      2'd0: return 9'(a) + 9'(b);
      2'd1: return 9'(a) - 9'(b);
      2'd2: return 9'(a) * 9'(b);
      default: return 9'(a / b);
    endcase
  endfunction

  function automatic logic [33:0] all_outs();
    return {req_ready, cmd_valid, cmd_data, out_valid, out_a, out_b,
            out_op, out_result, out_dz, err_unexp};
  endfunction

  task automatic observe();
    exp_t e;
    logic [9:0] c;
    int t;
    m_acc = req_valid && req_ready;
    m_rsp = rsp_valid;
    check("err_unexp", err_unexp, m_err);
    if (out_valid) begin
      if (m_exp.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        e = m_exp[0];
        check("out_a", out_a, e.a);
        check("out_b", out_b, e.b);
        check("out_op", out_op, e.op);
        check("out_result", out_result, e.res);
        check("out_dz", out_dz, e.dz);
        if (out_ready) void'(m_exp.pop_front());
      end
    end
    if (cmd_valid) begin
      if (m_cmd.size() == 0) check("spurious_cmd", cmd_valid, 0);
      else begin
        check("cmd_data", cmd_data, m_cmd[0]);
        if (cmd_ready) begin
          c = m_cmd.pop_front();
          t = ncyc + rsp_dly;
          if (pend_t.size() > 0 && t < pend_t[$]) t = pend_t[$];
          pend_v.push_back(alu(c[3:0], c[7:4], c[9:8]));
          pend_t.push_back(t);
        end
      end
    end
    if (m_acc) begin
      e.a  = req_a;
      e.b  = req_b;
      e.op = req_op;
      e.dz = (req_op == 2'd3) && (req_b == 4'd0);
      e.res = e.dz ? 9'd0 : alu(req_a, req_b, req_op);
      m_exp.push_back(e);
      if (!e.dz) m_cmd.push_back({req_op, req_b, req_a});
    end
    if (rsp_valid && m_rem == 0) m_err = 1;
    if (rsp_valid && m_rem > 0) m_rem--;
    if (cmd_valid && cmd_ready) m_rem++;
  endtask

  task automatic cyc();
    observe();
    @(negedge clk);
    ncyc++;
    rsp_valid = 0;
    rsp_data  = '0;
    if (!hold_rsp && pend_v.size() > 0 && pend_t[0] <= ncyc) begin
      rsp_valid = 1;
      rsp_data  = pend_v.pop_front();
      void'(pend_t.pop_front());
    end
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op);
    int n = 0;
    req_valid = 1;
    req_a = a;
    req_b = b;
    req_op = op;
    do begin
      cyc();
      n++;
    end while (!m_acc && n < 50);
    req_valid = 0;
    check("send_accept", m_acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 0;
    out_ready = 1;
    cmd_ready = 1;
    hold_rsp  = 0;
    while ((m_exp.size() > 0 || pend_v.size() > 0) && n < 300) begin
      cyc();
      n++;
    end
    check("drain_timeout", m_exp.size(), 0);
  endtask

  task automatic flush_model();
    m_exp.delete();
    m_cmd.delete();
    pend_v.delete();
    pend_t.delete();
    m_rem = 0;
    m_err = 0;
  endtask

  initial begin
    int n;
    reset = 0;
    #2;
    check("rst_init", all_outs(), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    check("rdy_pre", req_ready, 0);
    @(negedge clk);
    #1;
    check("rdy_post", req_ready, 1);

    // single remote add
    cmd_ready = 1;
    out_ready = 0;
    send(4'd3, 4'd5, 2'd0);
    check("cmd_valid_add", cmd_valid, 1);
    check("cmd_pack", cmd_data, 10'b00_0101_0011);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_rsp && n < 20);
    cyc();
    check("rsp_lat", out_valid, 1);
    check("add_res", out_result, 9'd8);
    drain();

    // local div-by-zero
    out_ready = 1;
    send(4'd9, 4'd0, 2'd3);
    check("dz_nocmd", cmd_valid, 0);
    cyc();
    check("dz_lat", out_valid, 1);
    check("dz_flag", out_dz, 1);
    drain();

    // ordering with a delayed remote response
    hold_rsp = 1;
    send(4'd4, 4'd4, 2'd2);
    send(4'd7, 4'd0, 2'd3);
    send(4'd1, 4'd1, 2'd0);
    repeat (6) cyc();
    drain();

    // fill the tracker
    hold_rsp = 1;
    out_ready = 0;
    for (int i = 0; i < 4; i++)
      send(4'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
    cyc();
    check("full_rdy", req_ready, 0);
    hold_rsp = 0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!out_valid && n < 20);
    check("pop_outv", out_valid, 1);
    check("pop_rdy", req_ready, 1);
    repeat (5) cyc();
    drain();

    // unexpected response
    pend_v.push_back(9'h0AA);
    pend_t.push_back(ncyc);
    repeat (3) cyc();
    check("err_set", err_unexp, 1);
    check("err_nov", out_valid, 0);
    repeat (3) cyc();
    check("err_stick", err_unexp, 1);

    // reset while a command is pending
    cmd_ready = 0;
    send(4'd2, 4'd3, 2'd0);
    check("mid_cv", cmd_valid, 1);
    reset = 0;
    #1;
    check("rst_mid", all_outs(), 0);
    flush_model();
    @(negedge clk);
    reset = 1;
    #1;
    check("rdy_pre2", req_ready, 0);
    @(negedge clk);
    #1;
    check("rdy_post2", req_ready, 1);
    check("empty_post2", {out_valid, cmd_valid}, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_a  = 4'($urandom);
      req_b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      req_op = 2'($urandom);
      cmd_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rsp_dly = $urandom_range(1, 5);
      cyc();
    end
    drain();
    check("final_err", err_unexp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
